// File: rtl/serial_pkg.sv
// Shared definitions for the serial word collector and the upstream shift-register control.
package serial_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;

  localparam logic DIR_LSB_FIRST = 1'b1;
  localparam logic DIR_MSB_FIRST = 1'b0;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } collector_state_t;

endpackage

// File: rtl/serial_bit_assembler.sv
// Shifts serial bits into a word, counts them and flags the cycle on which the word completes.
module serial_bit_assembler
  import serial_pkg::*;
#(
  parameter int WORD_W = serial_pkg::WORD_W,
  parameter int CNT_W  = serial_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              lsb_first,
  input  logic              frame_abort,
  output logic [CNT_W-1:0]  bit_count,
  output logic              word_done,
  output logic [WORD_W-1:0] word_data
);

  collector_state_t  state_q;
  logic [WORD_W-1:0] sreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dir_q;

  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] s,
                                                 input logic b, input logic dir);
    return (dir == DIR_LSB_FIRST) ? {b, s[WORD_W-1:1]} : {s[WORD_W-2:0], b};
  endfunction

  // The final bit is merged combinationally so the top can register the full word on the same edge.
  assign word_done = bit_valid && !frame_abort && (state_q == COLLECT)
                     && (cnt_q == CNT_W'(WORD_W - 1));
  assign word_data = shift_in(sreg_q, bit_in, dir_q);
  assign bit_count = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_LSB_FIRST;
    end else if (frame_abort) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else if (bit_valid) begin
      case (state_q)
        IDLE: begin
          dir_q   <= lsb_first;
          sreg_q  <= shift_in(sreg_q, bit_in, lsb_first);
          cnt_q   <= CNT_W'(1);
          state_q <= COLLECT;
        end
        COLLECT: begin
          sreg_q <= shift_in(sreg_q, bit_in, dir_q);
          if (cnt_q == CNT_W'(WORD_W - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// Collects serial bits into words and offers them on a one-entry valid/ready buffer with overrun detection.
module serial_word_collector
  import serial_pkg::*;
#(
  parameter int WORD_W = serial_pkg::WORD_W,
  parameter int CNT_W  = serial_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              lsb_first,
  input  logic              frame_abort,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [CNT_W-1:0]  bit_count,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr
);

  logic              word_done;
  logic [WORD_W-1:0] word_data;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  logic              overrun_q;
  logic              buf_free;

  serial_bit_assembler #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_assembler (
    .clk         (clk),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .lsb_first   (lsb_first),
    .frame_abort (frame_abort),
    .bit_count   (bit_count),
    .word_done   (word_done),
    .word_data   (word_data)
  );

  // A handshake on the completion cycle frees the slot in time for the new word.
  assign buf_free = !valid_q || word_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (word_done && buf_free) begin
        word_q  <= word_data;
        valid_q <= 1'b1;
      end else if (valid_q && word_ready) begin
        valid_q <= 1'b0;
      end

      if (word_done && !buf_free) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = overrun_q;
  assign busy       = (bit_count != '0);

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed self-checking bench for serial_word_collector.
module tb_serial_word_collector;

  logic        clk = 1'b0;
  logic        reset, bit_in, bit_valid, lsb_first, frame_abort, word_ready, overrun_clr;
  logic [15:0] word_out;
  logic        word_valid, busy, overrun;
  logic [4:0]  bit_count;

  int checks   = 0;
  int failures = 0;

  serial_word_collector dut (
    .clk         (clk),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .lsb_first   (lsb_first),
    .frame_abort (frame_abort),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .bit_count   (bit_count),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends the first n bits of w; lsb_first is inverted after the first bit to show it is ignored mid-word.
  task automatic send_bits(input logic [15:0] w, input logic lsb, input int gap,
                           input int n, input bit chk_cnt);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          if (chk_cnt) chk("cnt_hold", 32'(bit_count), 32'(i));
        end
      end
      bit_valid = 1'b1;
      lsb_first = (i == 0) ? lsb : ~lsb;
      bit_in    = lsb ? w[i] : w[15-i];
      tick();
      bit_valid = 1'b0;
      if (chk_cnt && i < 15) chk("cnt_step", 32'(bit_count), 32'(i + 1));
    end
  endtask

  initial begin
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; lsb_first = 1'b0;
    frame_abort = 1'b0; word_ready = 1'b0; overrun_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_word", 32'(word_out), 32'h0);
    chk("rst_valid", 32'(word_valid), 32'h0);
    chk("rst_cnt", 32'(bit_count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);

    // LSB-first 0xA5C3
    word_ready = 1'b1;
    send_bits(16'hA5C3, 1'b1, 0, 16, 1'b0);
    chk("a5c3_valid", 32'(word_valid), 32'h1);
    chk("a5c3_word", 32'(word_out), 32'hA5C3);
    chk("a5c3_cnt", 32'(bit_count), 32'h0);
    tick();
    chk("a5c3_valid_drop", 32'(word_valid), 32'h0);

    // MSB-first 0x1234 with one-cycle gaps
    send_bits(16'h1234, 1'b0, 1, 16, 1'b1);
    chk("1234_valid", 32'(word_valid), 32'h1);
    chk("1234_word", 32'(word_out), 32'h1234);
    chk("1234_cnt", 32'(bit_count), 32'h0);
    tick();

    // Back-to-back words: second completes exactly 16 cycles after the first
    send_bits(16'hFFFF, 1'b1, 0, 16, 1'b0);
    chk("b2b_w1_valid", 32'(word_valid), 32'h1);
    chk("b2b_w1_word", 32'(word_out), 32'hFFFF);
    send_bits(16'h0001, 1'b1, 0, 1, 1'b0);
    chk("b2b_gap_valid", 32'(word_valid), 32'h0);
    send_bits(16'h0000, 1'b1, 0, 15, 1'b0);
    chk("b2b_w2_valid", 32'(word_valid), 32'h1);
    chk("b2b_w2_word", 32'(word_out), 32'h0001);
    chk("b2b_ovr", 32'(overrun), 32'h0);
    tick();

    // Overrun: consumer stalled across two completions
    word_ready = 1'b0;
    send_bits(16'h00FF, 1'b1, 0, 16, 1'b0);
    chk("ovr_w1_word", 32'(word_out), 32'h00FF);
    chk("ovr_w1_ovr", 32'(overrun), 32'h0);
    send_bits(16'hFF00, 1'b1, 0, 16, 1'b0);
    chk("ovr_word_kept", 32'(word_out), 32'h00FF);
    chk("ovr_valid", 32'(word_valid), 32'h1);
    chk("ovr_set", 32'(overrun), 32'h1);
    word_ready = 1'b1;
    tick();
    chk("ovr_hs_valid", 32'(word_valid), 32'h0);
    chk("ovr_sticky", 32'(overrun), 32'h1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'h0);

    // Abort after 7 bits, abort wins over a simultaneous bit
    send_bits(16'h007F, 1'b1, 0, 7, 1'b0);
    chk("abt_pre_cnt", 32'(bit_count), 32'h7);
    frame_abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    frame_abort = 1'b0; bit_valid = 1'b0;
    chk("abt_cnt", 32'(bit_count), 32'h0);
    chk("abt_busy", 32'(busy), 32'h0);
    chk("abt_valid", 32'(word_valid), 32'h0);
    send_bits(16'hBEEF, 1'b0, 0, 16, 1'b0);
    chk("beef_valid", 32'(word_valid), 32'h1);
    chk("beef_word", 32'(word_out), 32'hBEEF);
    tick();

    // Reset mid-word with a word parked in the buffer
    word_ready = 1'b0;
    send_bits(16'h5A5A, 1'b1, 0, 16, 1'b0);
    send_bits(16'h01FF, 1'b1, 0, 9, 1'b0);
    chk("mid_cnt", 32'(bit_count), 32'h9);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_word", 32'(word_out), 32'h0);
    chk("mrst_valid", 32'(word_valid), 32'h0);
    chk("mrst_cnt", 32'(bit_count), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_ovr", 32'(overrun), 32'h0);
    word_ready = 1'b1;
    send_bits(16'h0F0F, 1'b0, 2, 16, 1'b1);
    chk("post_valid", 32'(word_valid), 32'h1);
    chk("post_word", 32'(word_out), 32'h0F0F);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream consumer of the 16-bit shift register's serial_out stream.
- Reassembles the serial bits into parallel words, either LSB-first (the register shifting right) or MSB-first (shifting left).
- Presents each completed word on a one-entry valid/ready output buffer for the next stage.
- Assembles the next word while the previous one waits; reports a lost word through a sticky overrun flag.

Parameters:
- WORD_W, 16, bits per assembled word; must match the upstream register width.
- CNT_W, 5, width of bit_count; must satisfy 2^CNT_W > WORD_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- bit_in  in  1  serial data bit, driven from the upstream serial_out
- bit_valid  in  1  bit_in is meaningful this cycle (upstream shift_right or shift_left was active)
- lsb_first  in  1  1 = bits arrive LSB first (right shift); 0 = MSB first (left shift); sampled only on the first bit of a word
- frame_abort  in  1  discard the partial word
- word_out  out  WORD_W  assembled word
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  consumer accepts word_out when word_valid && word_ready
- bit_count  out  CNT_W  bits collected in the current partial word, 0..WORD_W-1
- busy  out  1  partial word in progress (bit_count != 0)
- overrun  out  1  sticky: a completed word was dropped
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (synchronous, active-high) overrides everything. Post-reset values:
  - word_out = 0, word_valid = 0, bit_count = 0, busy = 0, overrun = 0
  - internal shift register = 0, latched direction = 1
- Collector FSM: IDLE, COLLECT.
  - IDLE + bit_valid: latch lsb_first as the word direction, shift in the bit, bit_count = 1, go to COLLECT.
  - COLLECT + bit_valid: shift in the bit and increment bit_count. lsb_first is ignored mid-word.
- Shift rules:
  - LSB-first: sreg <= {bit_in, sreg[WORD_W-1:1]}
  - MSB-first: sreg <= {sreg[WORD_W-2:0], bit_in}
- Completion: when bit_valid arrives with bit_count == WORD_W-1, the word is complete.
  - Full word = sreg combined with that last bit.
  - bit_count returns to 0 and the FSM returns to IDLE.
  - Latency: word_valid rises on the edge after the cycle carrying the 16th bit_valid.
- Output buffer (single entry):
  - word_valid clears on a handshake (word_valid && word_ready) unless a new word loads on the same edge.
  - Completion with the buffer free, or freed by a handshake on the same cycle: load word_out, word_valid = 1. Back-to-back words then flow with no gap.
  - Completion while word_valid = 1 and word_ready = 0: the new word is dropped, word_out is unchanged, and overrun is set on the next edge.
  - word_out is stable while word_valid && !word_ready.
- frame_abort:
  - Forces bit_count = 0, clears sreg, FSM = IDLE.
  - Wins over a bit_valid in the same cycle; that bit is discarded.
  - Does not touch the output buffer or overrun.
- overrun_clr with an overrun event in the same cycle: set wins.
- bit_valid = 0: all collector state holds. Gaps between bits are unlimited.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package serial_pkg holds:
  - WORD_W and CNT_W defaults
  - the collector state enum (IDLE, COLLECT)
  - the direction constants DIR_LSB_FIRST = 1 and DIR_MSB_FIRST = 0, shared with the shift-register control logic
- One natural sub-module, serial_bit_assembler, contains the sreg, the bit counter and the direction latch. It emits word_done plus the full word.
- The top level keeps the output buffer, the handshake and overrun.

Test Plan:
- LSB-first 0xA5C3, word_ready = 1: lsb_first = 1, 16 consecutive bit_valid with bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 -> word_out = 0xA5C3, word_valid high for 1 cycle, one edge after the 16th bit; bit_count back to 0.
- MSB-first 0x1234 with gaps: lsb_first = 0, bits 0001001000110100 with bit_valid every other cycle -> word_out = 0x1234; bit_count steps 1..15 and holds during gaps; lsb_first toggled mid-word has no effect.
- Back-to-back: 32 consecutive bits (0xFFFF then 0x0001, LSB-first), word_ready = 1 -> two word_valid pulses exactly 16 cycles apart; overrun = 0.
- Overrun: word_ready = 0, send 0x00FF then 0xFF00 -> word_out stays 0x00FF, overrun = 1 the edge after the second completion. Then word_ready = 1 -> handshake, word_valid = 0. overrun_clr -> overrun = 0.
- Abort, then reset mid-word:
  - 7 bits, then frame_abort asserted together with bit_valid -> bit_count = 0, busy = 0. Next 16 bits of 0xBEEF -> word_out = 0xBEEF.
  - Separately, reset after 9 bits -> all outputs = 0. A following full word assembles correctly.
